// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier among NREQ requesters,
// with credit-based flow control into a FWFT result FIFO. Optional stall counter: FPMUL_ARB_STATS_EN.
module fp_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [32*NREQ-1:0]      req_a,
    input  logic [32*NREQ-1:0]      req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    input  logic [31:0]             mul_prod,
    input  logic                    mul_exc,
    input  logic                    mul_ovf,
    input  logic                    mul_unf,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_prod,
    output logic [2:0]              rsp_flags
`ifdef FPMUL_ARB_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    prod;
        logic [2:0]     flags;
    } entry_t;

    logic [CW-1:0]  credit;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           grant_any;
    logic           in_flight;
    logic [IDW-1:0] issue_id;
    logic           pop;

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid requester after the last grant; nothing is offered without a free credit.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!grant_any && credit != '0 && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any)
            req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= IDW'(NREQ - 1);
            mul_a     <= '0;
            mul_b     <= '0;
            issue_id  <= '0;
            in_flight <= 1'b0;
            credit    <= CW'(DEPTH);
        end else begin
            in_flight <= grant_any;
            credit    <= credit - CW'(grant_any) + CW'(pop);
            if (grant_any) begin
                last     <= grant_idx;
                issue_id <= grant_idx;
                mul_a    <= req_a[32*int'(grant_idx) +: 32];
                mul_b    <= req_b[32*int'(grant_idx) +: 32];
            end
        end
    end

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign head      = mem[rd_ptr];
    assign rsp_id    = rsp_valid ? head.id    : '0;
    assign rsp_prod  = rsp_valid ? head.prod  : '0;
    assign rsp_flags = rsp_valid ? head.flags : '0;

    // Storage carries no reset so it maps onto plain RAM; validity lives in count.
    always_ff @(posedge clk) begin
        if (in_flight)
            mem[wr_ptr] <= '{id: issue_id, prod: mul_prod, flags: {mul_exc, mul_ovf, mul_unf}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_flight)
                wr_ptr <= wrap_inc(wr_ptr);
            if (pop)
                rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(in_flight) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && in_flight)
            assert (!(count == CW'(DEPTH) && !pop))
                else $error("result written into a full FIFO");
    end

`ifdef FPMUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (|req_valid && credit == '0 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based transaction model.
module tb_fp_mul_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ready;
    logic [31:0]  mul_a, mul_b, mul_prod;
    logic         mul_exc, mul_ovf, mul_unf;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_prod;
    logic [2:0]   rsp_flags;
`ifdef FPMUL_ARB_STATS_EN
    logic [15:0]  stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Reference float multiply (truncating, flush-to-zero); returns {prod, exc, ovf, unf}.
    function automatic logic [34:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {32'h0, 3'b100};
        if (ea == 0 || eb == 0)     return {s, 31'h0, 3'b000};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (m[47]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 3'b010};
        if (e <= 0)   return {s, 31'h0, 3'b001};
        return {s, e[7:0], m[45:23], 3'b000};
    endfunction

    assign {mul_prod, mul_exc, mul_ovf, mul_unf} = fpmul(mul_a, mul_b);

    fp_mul_arbiter #(.NREQ(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
        .mul_exc(mul_exc), .mul_ovf(mul_ovf), .mul_unf(mul_unf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_flags(rsp_flags)
`ifdef FPMUL_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] prod;
        logic [2:0]  flags;
    } ent_t;

    ent_t        fifo_m[$];
    ent_t        infl;
    logic        infl_v;
    logic [31:0] infl_a, infl_b;
    int          credit_m, last_m, stall_m;

    task automatic model_reset();
        fifo_m.delete();
        infl_v   = 1'b0;
        infl_a   = '0;
        infl_b   = '0;
        credit_m = 4;
        last_m   = 3;
        stall_m  = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, check at mid-cycle, then advance the model across the edge.
    task automatic step(input logic [3:0] v, input logic rr, input logic [127:0] a, input logic [127:0] b);
        int          gidx;
        logic [3:0]  exp_ready;
        logic        exp_rv, popm;
        logic [34:0] r;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #4;
        gidx = -1;
        if (credit_m > 0)
            for (int k = 1; k <= 4; k++)
                if (gidx < 0 && v[(last_m + k) % 4]) gidx = (last_m + k) % 4;
        exp_ready = (gidx < 0) ? 4'b0000 : (4'b0001 << gidx);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        exp_rv = (fifo_m.size() != 0);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id",    64'(rsp_id),    64'(fifo_m[0].id));
            chk("rsp_prod",  64'(rsp_prod),  64'(fifo_m[0].prod));
            chk("rsp_flags", 64'(rsp_flags), 64'(fifo_m[0].flags));
        end
        if (infl_v) begin
            chk("mul_a", 64'(mul_a), 64'(infl_a));
            chk("mul_b", 64'(mul_b), 64'(infl_b));
        end
`ifdef FPMUL_ARB_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
        if (|v && credit_m == 0 && stall_m != 65535) stall_m++;
        popm = exp_rv && rr;
        if (popm) void'(fifo_m.pop_front());
        if (infl_v) fifo_m.push_back(infl);
        infl_v = (gidx >= 0);
        if (gidx >= 0) begin
            infl_a = a[gidx*32 +: 32];
            infl_b = b[gidx*32 +: 32];
            r      = fpmul(infl_a, infl_b);
            infl   = '{id: gidx[1:0], prod: r[34:3], flags: r[2:0]};
            last_m = gidx;
        end
        credit_m = credit_m + (popm ? 1 : 0) - ((gidx >= 0) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1, rnd128(), rnd128());
    endtask

    initial begin
        logic [127:0] a, b;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        model_reset();
        #12;
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset mul_a", 64'(mul_a), 64'd0);
        chk("reset rsp_prod", 64'(rsp_prod), 64'd0);
`ifdef FPMUL_ARB_STATS_EN
        chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: 3.0 * 2.0 from requester 0
        a = '0; b = '0;
        a[31:0] = 32'h40400000;
        b[31:0] = 32'h40000000;
        step(4'b0001, 1'b1, a, b);
        idle(3);

        // Exception path: inf * 1.0 from requester 2
        a = rnd128(); b = rnd128();
        a[95:64] = 32'h7F800000;
        b[95:64] = 32'h3F800000;
        step(4'b0100, 1'b1, a, b);
        idle(3);

        // Round-robin with all requesters valid
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, rnd128(), rnd128());
        idle(3);

        // Backpressure: credits run out, then a single pop releases one grant
        for (int i = 0; i < 14; i++) step(4'b1111, 1'b0, rnd128(), rnd128());
        step(4'b1111, 1'b1, rnd128(), rnd128());
        step(4'b1111, 1'b0, rnd128(), rnd128());
        step(4'b1111, 1'b0, rnd128(), rnd128());
        idle(8);

        // Mid-operation reset with results in flight and queued
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, rnd128(), rnd128());
        #2;
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        #1;
        chk("async reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async reset req_ready", 64'(req_ready), 64'd0);
        chk("async reset mul_a", 64'(mul_a), 64'd0);
        chk("async reset mul_b", 64'(mul_b), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, rnd128(), rnd128());
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), rnd128(), rnd128());
        for (int i = 0; i < 100; i++)
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), rnd128(), rnd128());
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
